// File: rtl/scaler_pkg.sv
// Shared types for the scaler2 pipeline: step/position formats and the scaler_h FSM states.
// Position is 16.12 fixed point; step is 4.12 with 4096 meaning unity.
package scaler_pkg;

    localparam int STEP_FRAC = 12;
    localparam int STEP_ONE  = 4096;

    typedef logic [15:0] step_t;
    typedef logic [27:0] pos_t;

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        EMIT,
        DONE
    } scaler_h_state_e;

    function automatic logic [15:0] int_part(input pos_t p);
        return p[27:STEP_FRAC];
    endfunction

endpackage

// File: rtl/scaler_h_lerp.sv
// Two-stage interpolation MAC: weighted products, then sum/shift/clamp.
// SCALER_H_ROUND_EN selects round-half-up; otherwise the result is truncated.
module scaler_h_lerp #(
    parameter int PW = 8,
    parameter int C  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    input  logic [PW-1:0] p0,
    input  logic [PW-1:0] p1,
    input  logic [C-1:0]  fc,
    output logic          pix_valid,
    output logic [PW-1:0] pix
);

    localparam int MW = PW + C + 1;
    localparam logic [MW-1:0] PIX_MAX = MW'((1 << PW) - 1);

    logic [C:0]    w0;
    logic [MW-1:0] m0;
    logic [MW-1:0] m1;
    logic [MW-1:0] sum;
    logic [MW-1:0] res;
    logic          v1;

    always_comb begin
        w0  = {1'b1, {C{1'b0}}} - {1'b0, fc};
`ifdef SCALER_H_ROUND_EN
        sum = m0 + m1 + (MW'(1) << (C - 1));
`else
        sum = m0 + m1;
`endif
        res = sum >> C;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            m0        <= '0;
            m1        <= '0;
            pix_valid <= 1'b0;
            pix       <= '0;
        end else begin
            v1        <= valid;
            m0        <= MW'(p0) * MW'(w0);
            m1        <= MW'(p1) * MW'(fc);
            pix_valid <= v1;
            pix       <= (res > PIX_MAX) ? '1 : res[PW-1:0];
        end
    end

endmodule

// File: rtl/scaler_h.sv
// Horizontal linear-interpolation scaler: resamples each line by a 4.12 step.
// Build option SCALER_H_ROUND_EN enables round-half-up in the interpolator.
module scaler_h
    import scaler_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 8,
    parameter int COE_WIDTH     = 10,
    parameter int LINE_SIZE_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            h_scale_step,
    input  logic [15:0]            h_scale_line_size,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   ovf_o
);

    localparam int PW = PIXEL_WIDTH;
    localparam int C  = COE_WIDTH;
    localparam int CW = $clog2(LINE_SIZE_MAX + 1);

    scaler_h_state_e state;
    step_t           step_q;
    logic [15:0]     size_q;
    pos_t            pos;
    logic [15:0]     kl;
    logic            fresh;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   p0;
    logic [PW-1:0]   p1;
    logic            iss_v;
    logic [PW-1:0]   iss_p0;
    logic [PW-1:0]   iss_p1;
    logic [C-1:0]    iss_fc;
    logic [1:0]      hs_d;
    logic [1:0]      vs_d;

    step_t         step_in;
    logic [15:0]   size_now;
    pos_t          pos_nx;
    logic [16:0]   i1;
    logic [16:0]   i1_nx;
    logic [15:0]   kl_acc;
    logic [16:0]   kl_w;
    logic [16:0]   kl_acc_w;
    logic [16:0]   kl_eff_w;
    logic [CW-1:0] cnt_nx;
    logic          line_end;

    // kl is the index of the last accepted pixel; i1 is I+1 of the
    // current output position, so a match means p0/p1 bracket it.
    always_comb begin
        step_in  = (h_scale_step == '0) ? step_t'(STEP_ONE) : h_scale_step;
        size_now = vs_i ? h_scale_line_size : size_q;
        pos_nx   = pos + pos_t'(step_q);
        i1       = {1'b0, int_part(pos)} + 17'd1;
        i1_nx    = {1'b0, int_part(pos_nx)} + 17'd1;
        kl_acc   = fresh ? '0 : kl + 16'd1;
        kl_w     = {1'b0, kl};
        kl_acc_w = {1'b0, kl_acc};
        kl_eff_w = de_i ? kl_acc_w : kl_w;
        cnt_nx   = cnt + CW'(1);
        line_end = (16'(cnt_nx) == size_q)
                || (cnt_nx == CW'(LINE_SIZE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step_q <= step_t'(STEP_ONE);
            size_q <= '0;
            pos    <= '0;
            kl     <= '0;
            fresh  <= 1'b1;
            cnt    <= '0;
            p0     <= '0;
            p1     <= '0;
            iss_v  <= 1'b0;
            iss_p0 <= '0;
            iss_p1 <= '0;
            iss_fc <= '0;
            hs_d   <= '0;
            vs_d   <= '0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            iss_v <= 1'b0;
            hs_d  <= {hs_d[0], hs_i};
            vs_d  <= {vs_d[0], vs_i};
            hs_o  <= hs_d[1];
            vs_o  <= vs_d[1];
            if (vs_i) begin
                step_q <= step_in;
                size_q <= h_scale_line_size;
                ovf_o  <= 1'b0;
            end
            if (hs_i) begin
                pos   <= '0;
                cnt   <= '0;
                kl    <= '0;
                fresh <= !de_i;
                if (de_i) begin
                    p0 <= di_i;
                    p1 <= di_i;
                end
                state <= (size_now == '0) ? DONE : LINE;
            end else begin
                unique case (state)
                    LINE: begin
                        if (de_i) begin
                            p0    <= fresh ? di_i : p1;
                            p1    <= di_i;
                            kl    <= kl_acc;
                            fresh <= 1'b0;
                            if (i1 == kl_acc_w)
                                state <= EMIT;
                        end
                    end
                    EMIT: begin
                        pos <= pos_nx;
                        cnt <= cnt_nx;
                        // i1 < kl: output of an overrun pair, skipped
                        if (i1 == kl_w) begin
                            iss_v  <= 1'b1;
                            iss_p0 <= p0;
                            iss_p1 <= p1;
                            iss_fc <= pos[STEP_FRAC-1 -: C];
                        end
                        if (de_i) begin
                            p0    <= fresh ? di_i : p1;
                            p1    <= di_i;
                            kl    <= kl_acc;
                            fresh <= 1'b0;
                            if (i1_nx <= kl_w)
                                ovf_o <= 1'b1;
                        end
                        if (line_end)
                            state <= DONE;
                        else if (i1_nx > kl_eff_w)
                            state <= LINE;
                    end
                    default: ;
                endcase
            end
        end
    end

    scaler_h_lerp #(
        .PW (PW),
        .C  (C)
    ) u_lerp (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (iss_v),
        .p0        (iss_p0),
        .p1        (iss_p1),
        .fc        (iss_fc),
        .pix_valid (de_o),
        .pix       (do_o)
    );

endmodule
